// File: rtl/reg_dump_reader_if.sv
// Bus bundle for reg_dump_reader: dump control, register-file read port,
// output word stream with handshake, and status.
interface reg_dump_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_reg_num;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, abort, first_reg, last_reg, rd_data, out_ready,
    output rd_reg_num, out_valid, out_data, out_idx, out_last, busy, done, checksum
  );

  modport slave (
    output start, abort, first_reg, last_reg, rd_data, out_ready,
    input  rd_reg_num, out_valid, out_data, out_idx, out_last, busy, done, checksum
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register-file index range (wrapping modulo 2^ADDR_W), streams each
// value out over a valid/ready handshake and keeps a running checksum.
module reg_dump_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  reg_dump_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur_idx;
  logic [ADDR_W-1:0] r_end_idx;
  logic [ADDR_W-1:0] r_rd_reg_num;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_idx;
  logic              r_out_last;
  logic [DATA_W-1:0] r_checksum;
  logic              w_xfer;

  assign w_xfer = (r_state == SEND) && bus.out_ready && !bus.abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.start) w_next = FETCH;
      FETCH: w_next = SEND;
      SEND:  if (bus.out_ready) w_next = r_out_last ? DONE : FETCH;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.abort && r_state != IDLE) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cur_idx    <= '0;
      r_end_idx    <= '0;
      r_rd_reg_num <= '0;
      r_out_data   <= '0;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
      r_checksum   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_cur_idx  <= bus.first_reg;
        r_end_idx  <= bus.last_reg;
        r_checksum <= '0;
      end
      // The read index keeps tracking FETCH even when aborted; only the captured word is dropped.
      if (r_state == FETCH) begin
        r_rd_reg_num <= r_cur_idx;
        if (!bus.abort) begin
          r_out_data <= bus.rd_data;
          r_out_idx  <= r_cur_idx;
          r_out_last <= (r_cur_idx == r_end_idx);
        end
      end
      if (w_xfer) begin
        r_checksum <= r_checksum + r_out_data;
        if (!r_out_last) r_cur_idx <= r_cur_idx + 1'b1;
      end
    end
  end

  assign bus.rd_reg_num = (r_state == FETCH) ? r_cur_idx : r_rd_reg_num;
  assign bus.out_valid  = (r_state == SEND);
  assign bus.out_data   = r_out_data;
  assign bus.out_idx    = r_out_idx;
  assign bus.out_last   = r_out_last;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.checksum   = r_checksum;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_dump_reader;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] i;
    logic          l;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] regs [8];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;

  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = regs[bus.rd_reg_num];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending words of the current dump, plus flags for
  // the one-cycle fetch gap before each word and the completion cycle.
  word_t         q[$];
  word_t         w;
  bit            m_active  = 1'b0;
  bit            m_fetch   = 1'b0;
  bit            m_done    = 1'b0;
  logic [DW-1:0] m_sum     = '0;
  logic [AW-1:0] m_rd      = '0;
  int unsigned   n_xfer    = 0;

  always @(negedge clk) begin
    logic          exp_valid;
    logic [AW-1:0] exp_rd;
    int unsigned   n;
    logic [AW-1:0] k_idx;
    exp_valid = m_active && !m_fetch && !m_done;
    exp_rd    = (m_active && m_fetch && q.size() > 0) ? q[0].i : m_rd;
    if (chk_en) begin
      chk("busy", bus.busy, m_active);
      chk("done", bus.done, m_done);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("checksum", bus.checksum, m_sum);
      chk("rd_reg_num", bus.rd_reg_num, exp_rd);
      if (exp_valid && q.size() > 0) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_idx", bus.out_idx, q[0].i);
        chk("out_last", bus.out_last, q[0].l);
      end
    end
    if (rst) begin
      m_active = 0; m_fetch = 0; m_done = 0; m_sum = '0; m_rd = '0;
      q.delete();
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1; m_fetch = 1; m_done = 0; m_sum = '0; n_xfer = 0;
        q.delete();
        n = ((int'(bus.last_reg) - int'(bus.first_reg)) & 7) + 1;
        for (int unsigned k = 0; k < n; k++) begin
          k_idx = AW'((int'(bus.first_reg) + int'(k)) & 7);
          q.push_back('{d: regs[k_idx], i: k_idx, l: (k == n - 1)});
        end
      end
    end else if (bus.abort) begin
      if (m_fetch && q.size() > 0) m_rd = q[0].i;
      m_active = 0; m_fetch = 0; m_done = 0;
      q.delete();
    end else if (m_done) begin
      m_active = 0; m_done = 0;
    end else if (m_fetch) begin
      if (q.size() > 0) m_rd = q[0].i;
      m_fetch = 0;
    end else if (bus.out_ready && q.size() > 0) begin
      w = q.pop_front();
      m_sum = m_sum + w.d;
      n_xfer++;
      if (w.l) m_done = 1;
      else     m_fetch = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    bus.first_reg = f;
    bus.last_reg  = l;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk(name, seen, 1'b1);
    step();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) regs[k] = DW'(k);

    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_checksum", bus.checksum, 8'h00);
    chk("rst_rd_reg_num", bus.rd_reg_num, 3'd0);
    step();

    // Full range, identity register contents.
    bus.first_reg = 3'd0;
    bus.last_reg  = 3'd7;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk("lat_cycle1_valid", bus.out_valid, 1'b0);
    step();
    chk("lat_cycle2_valid", bus.out_valid, 1'b1);
    chk("first_word_idx", bus.out_idx, 3'd0);
    wait_done("t1_done");
    chk("t1_checksum", bus.checksum, 8'd28);
    chk("t1_words", n_xfer, 32'd8);

    // Wrapping range 6..1.
    for (int k = 0; k < 8; k++) regs[k] = DW'(k + 8'h10);
    start_dump(3'd6, 3'd1);
    wait_done("t2_done");
    chk("t2_checksum", bus.checksum, 8'h4E);
    chk("t2_words", n_xfer, 32'd4);

    // Single word with backpressure.
    bus.out_ready = 1'b0;
    start_dump(3'd3, 3'd3);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", bus.out_valid, 1'b1);
      chk("t3_hold_data", bus.out_data, 8'h13);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_done", bus.done, 1'b1);
    chk("t3_checksum", bus.checksum, 8'h13);
    step();

    // Abort during the third SEND.
    start_dump(3'd0, 3'd7);
    for (int c = 0; c < 50; c++) begin
      if (bus.out_valid && n_xfer == 2) break;
      step();
    end
    chk("t4_third_send", bus.out_valid && n_xfer == 2, 1'b1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t4_busy", bus.busy, 1'b0);
    chk("t4_valid", bus.out_valid, 1'b0);
    chk("t4_checksum", bus.checksum, 8'h21);
    step();
    chk("t4_no_done", bus.done, 1'b0);

    // Reset mid-dump, then a single-word dump of reg[2].
    start_dump(3'd4, 3'd7);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", bus.out_valid, 1'b0);
    chk("t5_data", bus.out_data, 8'h00);
    chk("t5_idx", bus.out_idx, 3'd0);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_checksum", bus.checksum, 8'h00);
    start_dump(3'd2, 3'd2);
    wait_done("t5_done");
    chk("t5_sum2", bus.checksum, 8'h12);
    chk("t5_words", n_xfer, 32'd1);

    // Abort+start together in IDLE starts; start while busy is ignored.
    bus.abort = 1'b1;
    start_dump(3'd0, 3'd3);
    bus.abort = 1'b0;
    step();
    start_dump(3'd5, 3'd7);
    wait_done("t6_done");
    chk("t6_checksum", bus.checksum, 8'h46);
    chk("t6_words", n_xfer, 32'd4);
    step(); step();
    chk("t6_idle_hold", bus.checksum, 8'h46);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, register data width.
- ADDR_W, 3, register index width (8 registers).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a dump; sampled only in IDLE.
REQ-005 abort  input  1  cancel an in-progress dump.
REQ-006 first_reg  input  ADDR_W  first register index to dump; sampled with start.
REQ-007 last_reg  input  ADDR_W  last register index to dump; sampled with start.
REQ-008 rd_reg_num  output  ADDR_W  read-port index driven to the register file.
REQ-009 rd_data  input  DATA_W  combinational read data returned by the register file for rd_reg_num.
REQ-010 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  DATA_W  captured register value.
REQ-013 out_idx  output  ADDR_W  index of the register in out_data.
REQ-014 out_last  output  1  high with the final word of the dump.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 checksum  output  DATA_W  sum mod 2^DATA_W of all words transferred in the current or most recent dump.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, SEND, DONE.
REQ-019 IDLE + start=1 at an edge: latch first_reg into cur_idx and last_reg into end_idx, clear checksum to 0, go to FETCH.
REQ-020 In FETCH, rd_reg_num SHALL equal cur_idx; at the next edge out_data<=rd_data, out_idx<=cur_idx, out_last<=(cur_idx==end_idx), go to SEND.
REQ-021 Outside FETCH, rd_reg_num SHALL hold its last value (0 after reset).
REQ-022 out_valid SHALL be 1 exactly in SEND; first out_valid SHALL occur 2 cycles after the start edge.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-024 Transfer occurs at an edge with out_valid=1 and out_ready=1; checksum<=checksum+out_data (mod 2^DATA_W).
REQ-025 On a transfer with out_last=0: cur_idx<=cur_idx+1 (7 wraps to 0), go to FETCH. Sustained throughput is therefore 1 word per 2 cycles.
REQ-026 On a transfer with out_last=1: go to DONE; done=1 for that one DONE cycle, then IDLE.
REQ-027 Word count SHALL be ((last_reg-first_reg) mod 8)+1; first_reg==last_reg yields exactly one word; last_reg<first_reg wraps through index 7 to 0.
REQ-028 start SHALL be ignored while busy=1; first_reg/last_reg changes after the start edge SHALL have no effect.
REQ-029 abort=1 at an edge in FETCH/SEND/DONE SHALL force IDLE next cycle, with out_valid=0 and no done pulse; a simultaneous transfer SHALL NOT update checksum.
REQ-030 abort in IDLE SHALL be ignored; abort and start together in IDLE SHALL start the dump.
REQ-031 checksum SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-032 rst=1 at an edge SHALL, from any state including mid-dump, go to IDLE with out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, checksum=0, rd_reg_num=0, cur_idx=0, end_idx=0.
REQ-033 rst SHALL take priority over start, abort and transfer.

Verification
REQ-034 Reg model reg[k]=k, first=0, last=7, out_ready=1 -> words 0..7 on cycles 2,4,...,16 after start; out_last only with idx 7; done pulse; checksum=28.
REQ-035 first=6, last=1, reg[k]=k+0x10 -> idx sequence 6,7,0,1 with data 0x16,0x17,0x10,0x11; checksum=0x4E.
REQ-036 first=last=3, out_ready held 0 for 5 cycles -> out_valid held with out_data=reg[3] stable; transfers on the first ready cycle, then done.
REQ-037 Abort asserted during the 3rd SEND with out_ready=1 -> IDLE next cycle, no done pulse, checksum equals the sum of the first 2 words only.
REQ-038 rst asserted mid-dump, then start with first=2, last=2 -> all outputs reset, then a clean single-word dump of reg[2].
REQ-039 start pulsed while busy -> ignored; current dump completes with its original word count.
